// File: rtl/iddmm_pkg.sv
// Shared types and constants for the IDDMM sequencing controllers.
package iddmm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUTPUT
  } iddmm_seq_state_t;

  // Parked operand addresses presented whenever no issue is live.
  function automatic int unsigned park_i(input int unsigned n);
    return n - 1;
  endfunction

  function automatic int unsigned park_j(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/iddmm_idx_gen.sv
// Nested i/j index generator: j runs 0..words then wraps, i advances on each wrap.
module iddmm_idx_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W:0]   words,
  output logic [ADDR_W:0]   i,
  output logic [ADDR_W:0]   j,
  output logic              last
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
    end else if (start) begin
      i <= '0;
      j <= '0;
    end else if (step) begin
      if (j == words) begin
        j <= '0;
        i <= i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

  assign last = (i == words - 1'b1) && (j == words);

endmodule

// File: rtl/iddmm_seq_ctrl.sv
// Task sequencer for the IDDMM array: issues the i/j operand schedule, waits for the
// datapath, then streams the selected result words out under valid/ready.
module iddmm_seq_ctrl
  import iddmm_pkg::*;
#(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              task_req,
  input  logic [ADDR_W:0]   cfg_words,
  input  logic              task_abort,
  output logic              busy,
  output logic              task_err,
  output logic [ADDR_W:0]   rd_data_addr_i,
  output logic [ADDR_W:0]   rd_data_addr_j,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] i_cnt,
  output logic [ADDR_W:0]   j_cnt,
  output logic              cnt_valid,
  input  logic              cal_done,
  input  logic              cal_sign,
  output logic              fifo_rd_en,
  input  logic [K-1:0]      fifo_rd_data_a,
  input  logic [K-1:0]      fifo_rd_data_sub,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [K-1:0]      res_data,
  output logic              res_last
);

  typedef logic [ADDR_W:0] cnt_t;

  localparam cnt_t PARK_I = cnt_t'(park_i(N));
  localparam cnt_t PARK_J = cnt_t'(park_j(N));
  localparam cnt_t N_W    = cnt_t'(N);

  iddmm_seq_state_t state;
  logic             task_req_d1;
  cnt_t             words_q;
  cnt_t             out_cnt;
  logic             sign_q;

  logic start_edge, cfg_legal, idx_start, idx_step, idx_last, handshake;
  cnt_t idx_i, idx_j;

  assign start_edge = task_req && !task_req_d1;
  assign cfg_legal  = (cfg_words != '0) && (cfg_words <= N_W);
  assign idx_start  = (state == IDLE) && start_edge && cfg_legal;
  assign idx_step   = (state == ISSUE) && !idx_last && !task_abort;

  iddmm_idx_gen #(.ADDR_W(ADDR_W)) u_idx_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .start (idx_start),
    .step  (idx_step),
    .words (words_q),
    .i     (idx_i),
    .j     (idx_j),
    .last  (idx_last)
  );

  // Addresses come straight from the index registers while an issue is live, else parked.
  assign rd_data_addr_i = addr_valid ? idx_i : PARK_I;
  assign rd_data_addr_j = addr_valid ? idx_j : PARK_J;

  assign handshake  = res_valid && res_ready;
  assign fifo_rd_en = handshake;
  assign res_last   = res_valid && (out_cnt == words_q - 1'b1);
  assign res_data   = sign_q ? fifo_rd_data_sub : fifo_rd_data_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      task_req_d1 <= 1'b0;
      words_q     <= '0;
      out_cnt     <= '0;
      sign_q      <= 1'b0;
      busy        <= 1'b0;
      task_err    <= 1'b0;
      addr_valid  <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      task_req_d1 <= task_req;
      task_err    <= 1'b0;
      if (task_abort && state != IDLE) begin
        state      <= IDLE;
        busy       <= 1'b0;
        addr_valid <= 1'b0;
        res_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              if (cfg_legal) begin
                state      <= ISSUE;
                words_q    <= cfg_words;
                busy       <= 1'b1;
                addr_valid <= 1'b1;
              end else begin
                task_err <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (idx_last) begin
              state      <= WAIT;
              addr_valid <= 1'b0;
            end
          end
          WAIT: begin
            if (cal_done) begin
              state     <= OUTPUT;
              sign_q    <= cal_sign;
              out_cnt   <= '0;
              res_valid <= 1'b1;
            end
          end
          OUTPUT: begin
            if (handshake) begin
              out_cnt <= out_cnt + 1'b1;
              if (out_cnt == words_q - 1'b1) begin
                state     <= IDLE;
                busy      <= 1'b0;
                res_valid <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Counter pipe trails the addresses by one cycle; an abort also kills the trailing valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt     <= '0;
      j_cnt     <= '0;
      cnt_valid <= 1'b0;
    end else begin
      i_cnt     <= rd_data_addr_i[ADDR_W-1:0];
      j_cnt     <= rd_data_addr_j;
      cnt_valid <= addr_valid && !task_abort;
    end
  end

endmodule

// File: tb/tb_iddmm_seq_ctrl.sv
// Scoreboard bench for iddmm_seq_ctrl: directed tasks, queue-based address and result checking.
module tb_iddmm_seq_ctrl;

  localparam int K      = 256;
  localparam int N      = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              task_req;
  logic [ADDR_W:0]   cfg_words;
  logic              task_abort;
  logic              busy, task_err;
  logic [ADDR_W:0]   rd_data_addr_i, rd_data_addr_j;
  logic              addr_valid;
  logic [ADDR_W-1:0] i_cnt;
  logic [ADDR_W:0]   j_cnt;
  logic              cnt_valid;
  logic              cal_done, cal_sign;
  logic              fifo_rd_en;
  logic [K-1:0]      fifo_rd_data_a, fifo_rd_data_sub;
  logic              res_valid, res_ready;
  logic [K-1:0]      res_data;
  logic              res_last;

  iddmm_seq_ctrl #(.K(K), .N(N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .task_req(task_req), .cfg_words(cfg_words),
    .task_abort(task_abort), .busy(busy), .task_err(task_err),
    .rd_data_addr_i(rd_data_addr_i), .rd_data_addr_j(rd_data_addr_j),
    .addr_valid(addr_valid), .i_cnt(i_cnt), .j_cnt(j_cnt), .cnt_valid(cnt_valid),
    .cal_done(cal_done), .cal_sign(cal_sign), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data_a(fifo_rd_data_a), .fifo_rd_data_sub(fifo_rd_data_sub),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Show-ahead FIFO model for both result FIFOs.
  logic [K-1:0] mem_a [N];
  logic [K-1:0] mem_s [N];
  logic [4:0]   rp;
  logic         fifo_clr;
  always @(posedge clk) begin
    if (fifo_clr) rp <= '0;
    else if (fifo_rd_en) rp <= rp + 5'd1;
  end
  assign fifo_rd_data_a   = mem_a[rp[3:0]];
  assign fifo_rd_data_sub = mem_s[rp[3:0]];

  typedef struct packed { logic [ADDR_W:0] i; logic [ADDR_W:0] j; } addr_exp_t;
  typedef struct packed { logic [K-1:0] data; logic last; } res_exp_t;
  addr_exp_t exp_addr[$];
  res_exp_t  exp_res[$];

  // Monitor: pops and compares whenever the DUT presents an issue or a result beat.
  logic            mon_en = 1'b0;
  logic            have_prev = 1'b0;
  logic [ADDR_W:0] prev_i, prev_j;
  logic            prev_av, prev_abort, prev_stall, prev_last;
  logic [K-1:0]    prev_data;
  always @(negedge clk) begin
    if (mon_en) begin
      if (addr_valid) begin
        if (exp_addr.size() == 0) check("addr_extra", K'(1), K'(0));
        else begin
          addr_exp_t e;
          e = exp_addr.pop_front();
          check("addr", K'({rd_data_addr_i, rd_data_addr_j}), K'({e.i, e.j}));
        end
      end
      if (have_prev) begin
        check("pipe_i", K'(i_cnt), K'(prev_i[ADDR_W-1:0]));
        check("pipe_j", K'(j_cnt), K'(prev_j));
        check("pipe_valid", K'(cnt_valid), K'(prev_av && !prev_abort));
      end
      if (res_valid) begin
        check("rd_en", K'(fifo_rd_en), K'(res_ready));
        if (prev_stall) begin
          check("stall_data", res_data, prev_data);
          check("stall_last", K'(res_last), K'(prev_last));
        end
        if (res_ready) begin
          if (exp_res.size() == 0) check("res_extra", K'(1), K'(0));
          else begin
            res_exp_t r;
            r = exp_res.pop_front();
            check("res_data", res_data, r.data);
            check("res_last", K'(res_last), K'(r.last));
          end
        end
      end else begin
        check("rd_en_idle", K'(fifo_rd_en), K'(0));
      end
      have_prev  = 1'b1;
      prev_i     = rd_data_addr_i;
      prev_j     = rd_data_addr_j;
      prev_av    = addr_valid;
      prev_abort = task_abort;
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
      prev_last  = res_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load FIFO contents and push expected addresses and result beats for a W-word task.
  task automatic prep(input int w, input int base_a, input int base_s, input bit sign);
    for (int k = 0; k < N; k++) begin
      mem_a[k] = K'(base_a + k);
      mem_s[k] = K'(base_s + k);
    end
    for (int i = 0; i < w; i++)
      for (int j = 0; j <= w; j++)
        exp_addr.push_back('{i: 5'(i), j: 5'(j)});
    for (int k = 0; k < w; k++)
      exp_res.push_back('{data: K'(sign ? base_s + k : base_a + k), last: (k == w - 1)});
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  task automatic start_task(input int w, input bit hold);
    cfg_words = 5'(w);
    task_req  = 1'b1;
    tick();
    check("start_busy", K'(busy), K'(1));
    check("start_addr_valid", K'(addr_valid), K'(1));
    if (!hold) task_req = 1'b0;
  endtask

  task automatic issue_phase(output int n);
    int guard = 0;
    n = 0;
    while (addr_valid && guard < 400) begin
      n++;
      guard++;
      tick();
    end
    if (guard >= 400) check("issue_timeout", K'(1), K'(0));
    check("wait_busy", K'(busy), K'(1));
  endtask

  task automatic do_cal(input bit sign);
    tick();
    tick();
    check("wait_no_res", K'(res_valid), K'(0));
    cal_done = 1'b1;
    cal_sign = sign;
    tick();
    cal_done = 1'b0;
    cal_sign = 1'b0;
    check("first_res_valid", K'(res_valid), K'(1));
  endtask

  task automatic output_phase(input int w, input bit toggle);
    int  pops = 0;
    int  cyc  = 0;
    bit  hs, lst;
    while (busy && cyc < 400) begin
      res_ready = toggle ? ~cyc[0] : 1'b1;
      hs  = res_valid && res_ready;
      lst = res_last;
      tick();
      if (hs) pops++;
      if (hs && lst) check("busy_after_last", K'(busy), K'(0));
      cyc++;
    end
    if (cyc >= 400) check("output_timeout", K'(1), K'(0));
    res_ready = 1'b1;
    check("pops", K'(pops), K'(w));
    check("res_queue_empty", K'(exp_res.size()), K'(0));
    check("addr_queue_empty", K'(exp_addr.size()), K'(0));
  endtask

  task automatic full_task(input int w, input int base_a, input int base_s, input bit sign,
                           input bit toggle);
    int n;
    prep(w, base_a, base_s, sign);
    start_task(w, 1'b0);
    issue_phase(n);
    check("issue_cycles", K'(n), K'(w * (w + 1)));
    do_cal(sign);
    output_phase(w, toggle);
  endtask

  task automatic check_parked_idle(input string tag);
    check({tag, "_busy"}, K'(busy), K'(0));
    check({tag, "_addr_valid"}, K'(addr_valid), K'(0));
    check({tag, "_res_valid"}, K'(res_valid), K'(0));
    check({tag, "_park"}, K'({rd_data_addr_i, rd_data_addr_j}), K'({5'd15, 5'd31}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_seen;
    logic [ADDR_W:0] bad_cfg [2];
    rst_n      = 1'b0;
    task_req   = 1'b0;
    cfg_words  = '0;
    task_abort = 1'b0;
    cal_done   = 1'b0;
    cal_sign   = 1'b0;
    res_ready  = 1'b1;
    fifo_clr   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", K'({rd_data_addr_i, rd_data_addr_j}), K'({5'd15, 5'd31}));
    check("rst_cnt", K'({i_cnt, j_cnt}), K'(0));
    check("rst_valids", K'({addr_valid, cnt_valid, res_valid, res_last, fifo_rd_en}), K'(0));
    check("rst_busy_err", K'({busy, task_err}), K'(0));
    rst_n = 1'b1;
    tick();
    fifo_clr = 1'b0;
    mon_en   = 1'b1;

    // Maximum length, unsubtracted result.
    full_task(16, 'h5000, 'h9000, 1'b0, 1'b0);
    tick();

    // Three words taken from the subtracted FIFO.
    full_task(3, 'h1, 'hA, 1'b1, 1'b0);
    tick();

    // Four words with backpressure on alternate cycles.
    full_task(4, 'h700, 'h800, 1'b0, 1'b1);
    tick();

    // Illegal lengths.
    bad_cfg[0] = 5'd0;
    bad_cfg[1] = 5'd17;
    for (int b = 0; b < 2; b++) begin
      cfg_words = bad_cfg[b];
      task_req  = 1'b1;
      tick();
      check("err_pulse", K'(task_err), K'(1));
      check("err_busy", K'({busy, addr_valid}), K'(0));
      tick();
      check("err_one_cycle", K'(task_err), K'(0));
      check("err_busy2", K'({busy, addr_valid}), K'(0));
      task_req = 1'b0;
      tick();
    end

    // Abort in the middle of ISSUE, then a clean task.
    prep(4, 'h300, 'h400, 1'b0);
    start_task(4, 1'b0);
    repeat (4) tick();
    task_abort = 1'b1;
    tick();
    task_abort = 1'b0;
    check_parked_idle("abort_issue");
    exp_addr.delete();
    exp_res.delete();
    tick();
    full_task(3, 'h20, 'h30, 1'b0, 1'b0);
    tick();

    // Abort while beat 2 is presented, then a clean task.
    prep(4, 'h40, 'h50, 1'b1);
    start_task(4, 1'b0);
    issue_phase(n);
    check("issue_cycles_ab", K'(n), K'(20));
    do_cal(1'b1);
    tick();
    res_ready  = 1'b0;
    task_abort = 1'b1;
    tick();
    task_abort = 1'b0;
    res_ready  = 1'b1;
    check_parked_idle("abort_output");
    exp_addr.delete();
    exp_res.delete();
    tick();
    full_task(2, 'h60, 'h70, 1'b1, 1'b0);
    tick();

    // Request held high through completion, with a stray cal_done during ISSUE.
    prep(2, 'h80, 'h90, 1'b0);
    start_task(2, 1'b1);
    tick();
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    check("stray_cal_issue", K'(addr_valid), K'(1));
    check("stray_cal_no_res", K'(res_valid), K'(0));
    issue_phase(n);
    check("issue_cycles_rest", K'(n), K'(4));
    do_cal(1'b0);
    output_phase(2, 1'b0);
    busy_seen = 0;
    repeat (8) begin
      tick();
      busy_seen += int'(busy);
    end
    check("no_restart", K'(busy_seen), K'(0));
    task_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
